pipe_reg_elastic: RTL and testbench

PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

---
 rtl/pipe_reg_elastic_pkg.sv | 17 +
 rtl/pipe_reg_elastic_slot.sv | 111 +++++++++++
 rtl/pipe_reg_elastic.sv | 92 +++++++++
 tb/tb_pipe_reg_elastic.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_elastic_pkg.sv
// Shared types and helpers for the elastic pipeline register.
// Holds the per-slot state encoding and the occupancy-width function.
package pipe_reg_pkg;

    // Fill level of one two-entry slot: main entry only (ONE) or main + skid (TWO).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slot_state_e;

    // Bits needed to count 0..2*depth words held across the whole chain.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_elastic_slot.sv
// One elastic stage: a main register plus a skid register.
// Upstream ready is registered, so there is no combinational path from
// the downstream ready to the upstream ready.
module pipe_skid_slot
    import pipe_reg_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    slot_state_e       state_q, state_d;
    logic              ready_q, ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = (state_q != EMPTY) & out_ready;

    // Next-state and entry update for the two-entry slot; flush wins over any transfer.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        state_d     = TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                TWO: begin
                    // ready_q is low here, so only the output side can move.
                    if (out_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
        ready_d = (state_d != TWO);
    end

    // Slot registers; reset clears every entry and holds ready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            ready_q     <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_ctrl  = (state_q != EMPTY) ? main_ctrl_q : '0;
    assign out_data  = main_data_q;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH cascaded skid slots plus a word counter.
// Control is zeroed on bubbles; data passes through unmodified.
module pipe_reg_elastic
    import pipe_reg_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned DEPTH  = 1
) (
    input  logic                         Clk,
    input  logic                         Clr_n,
    input  logic                         Flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    // Chain nodes: index g feeds slot g, index g+1 is its output.
    logic              valid_c [DEPTH+1];
    logic              ready_c [DEPTH+1];
    logic [CTRL_W-1:0] ctrl_c  [DEPTH+1];
    logic [DATA_W-1:0] data_c  [DEPTH+1];

    logic              in_fire;
    logic              out_fire;
    logic [OCC_W-1:0]  occ_q, occ_d;

    assign valid_c[0]     = in_valid;
    assign ctrl_c[0]      = in_ctrl;
    assign data_c[0]      = in_data;
    assign ready_c[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_skid_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (Clk),
            .rst_n     (Clr_n),
            .flush     (Flush),
            .in_valid  (valid_c[g]),
            .in_ready  (ready_c[g]),
            .in_ctrl   (ctrl_c[g]),
            .in_data   (data_c[g]),
            .out_valid (valid_c[g+1]),
            .out_ready (ready_c[g+1]),
            .out_ctrl  (ctrl_c[g+1]),
            .out_data  (data_c[g+1])
        );
    end

    assign in_ready  = ready_c[0] & ~Flush;
    assign out_valid = valid_c[DEPTH];
    assign out_ctrl  = ctrl_c[DEPTH];
    assign out_data  = data_c[DEPTH];

    // Boundary transfers; a flush cancels the output side as well.
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & ~Flush;

    // Word count: up on accept, down on emit, unchanged when both happen.
    always_comb begin
        occ_d = occ_q;
        if (Flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy register, cleared asynchronously with the slots.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: four DUTs (DEPTH 1..4) share clock and reset.
// Each has an expected-word queue fed at acceptance and drained by a monitor.
module tb_pipe_reg_elastic;

    localparam int CW = 16;
    localparam int DW = 96;
    localparam int NI = 4;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } word_t;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    logic          iv   [NI];
    logic          ir   [NI];
    logic          ov   [NI];
    logic          ordy [NI];
    logic          fl   [NI];
    logic [CW-1:0] ictl [NI];
    logic [CW-1:0] octl [NI];
    logic [DW-1:0] idat [NI];
    logic [DW-1:0] odat [NI];
    logic [3:0]    occ  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned D = g + 1;
        logic [$clog2(2*D+1)-1:0] occ_raw;
        pipe_reg_elastic #(
            .CTRL_W (CW),
            .DATA_W (DW),
            .DEPTH  (D)
        ) u_dut (
            .Clk       (clk),
            .Clr_n     (clr_n),
            .Flush     (fl[g]),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_ctrl   (ictl[g]),
            .in_data   (idat[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_ctrl  (octl[g]),
            .out_data  (odat[g]),
            .occupancy (occ_raw)
        );
        assign occ[g] = 4'(occ_raw);
    end

    word_t exp_q [NI][$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    rst_pulses = 0;
    int    rst_seen = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", nm, inst, act, exp_v);
        end
    endtask

    task automatic chkd(input string nm, input int inst, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", nm, inst, act, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] mkdat(input int j);
        return {32'hCAFE_0000 + 32'(j), 32'h5A5A_5A5A ^ 32'(j), 32'(j * 7)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side: record every word that will be accepted at the coming edge.
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            if (clr_n && fl[i]) chk("in_ready_during_flush", i, 32'(ir[i]), 0);
            if (clr_n && iv[i] && ir[i] && !fl[i])
                exp_q[i].push_back(word_t'{c: ictl[i], d: idat[i]});
        end
    end

    // Output side: compare emitted words and status against the queue model.
    logic  pv  [NI];
    logic  pr  [NI];
    logic  pok [NI];
    word_t pw  [NI];
    always @(negedge clk) begin : mon
        word_t w;
        if (rst_pulses != rst_seen) begin
            rst_seen = rst_pulses;
            for (int i = 0; i < NI; i++) begin
                exp_q[i].delete();
                pok[i] = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (!clr_n) begin
                exp_q[i].delete();
                pok[i] = 1'b0;
                chk("rst_out_valid", i, 32'(ov[i]), 0);
                chk("rst_in_ready", i, 32'(ir[i]), 0);
                chk("rst_occupancy", i, 32'(occ[i]), 0);
            end else begin
                chk("occupancy", i, 32'(occ[i]), exp_q[i].size());
                chk("occ_bound", i, 32'(occ[i] <= 4'(2 * (i + 1))), 1);
                if (exp_q[i].size() == 2 * (i + 1)) chk("in_ready_full", i, 32'(ir[i]), 0);
                if (exp_q[i].size() == 0) chk("out_valid_empty", i, 32'(ov[i]), 0);
                if (!ov[i]) chk("out_ctrl_bubble", i, 32'(octl[i]), 0);
                if (pok[i] && pv[i] && !pr[i]) begin
                    chk("stall_valid", i, 32'(ov[i]), 1);
                    chk("stall_ctrl", i, 32'(octl[i]), 32'(pw[i].c));
                    chkd("stall_data", i, odat[i], pw[i].d);
                end
                if (fl[i]) begin
                    exp_q[i].delete();
                    pok[i] = 1'b0;
                end else begin
                    if (ov[i] && ordy[i]) begin
                        if (exp_q[i].size() == 0) begin
                            chk("spurious_word", i, 32'(ov[i]), 0);
                        end else begin
                            w = exp_q[i].pop_front();
                            chk("order_ctrl", i, 32'(octl[i]), 32'(w.c));
                            chkd("order_data", i, odat[i], w.d);
                        end
                    end
                    pok[i] = 1'b1;
                    pv[i]  = ov[i];
                    pr[i]  = ordy[i];
                    pw[i]  = word_t'{c: octl[i], d: odat[i]};
                end
            end
        end
    end

    initial begin
        clr_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; fl[i] = 1'b0;
            ictl[i] = '0; idat[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 clr_n = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) chk("ready_after_reset", i, 32'(ir[i]), 1);

        // DEPTH=1 streaming, no backpressure
        ordy[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            iv[0] = 1'b1; ictl[0] = CW'(k); idat[0] = mkdat(k);
            tick();
            chk("d1_valid", 0, 32'(ov[0]), 1);
            chk("d1_ctrl", 0, 32'(octl[0]), k);
            chkd("d1_data", 0, odat[0], mkdat(k));
            chk("d1_occ", 0, 32'(occ[0]), 1);
        end
        iv[0] = 1'b0;
        tick();
        chk("d1_idle_occ", 0, 32'(occ[0]), 0);
        chk("d1_idle_valid", 0, 32'(ov[0]), 0);
        ordy[0] = 1'b0;

        // DEPTH=2 fill under backpressure
        for (int j = 1; j <= 5; j++) begin
            iv[1] = 1'b1; ictl[1] = CW'(16'h10 + j); idat[1] = mkdat(j);
            tick();
            if (j >= 2) begin
                chk("fill_head_ctrl", 1, 32'(octl[1]), 32'h11);
                chkd("fill_head_data", 1, odat[1], mkdat(1));
            end
            if (j >= 4) begin
                chk("fill_in_ready", 1, 32'(ir[1]), 0);
                chk("fill_occ", 1, 32'(occ[1]), 4);
            end
        end
        iv[1] = 1'b0;

        // DEPTH=2 drain
        for (int k = 1; k <= 4; k++) begin
            chk("drain_ctrl", 1, 32'(octl[1]), 32'(16'h10 + k));
            chkd("drain_data", 1, odat[1], mkdat(k));
            ordy[1] = 1'b1;
            tick();
            chk("drain_occ", 1, 32'(occ[1]), 4 - k);
            if (k == 1) chk("drain_ready_k1", 1, 32'(ir[1]), 0);
            if (k == 2) chk("drain_ready_k2", 1, 32'(ir[1]), 1);
        end
        chk("drain_empty_valid", 1, 32'(ov[1]), 0);
        ordy[1] = 1'b0;

        // DEPTH=2 flush at occupancy 3 with a simultaneous input
        for (int j = 1; j <= 3; j++) begin
            iv[1] = 1'b1; ictl[1] = CW'(16'h20 + j); idat[1] = mkdat(32 + j);
            tick();
        end
        chk("preflush_occ", 1, 32'(occ[1]), 3);
        iv[1] = 1'b1; ictl[1] = 16'h002F; idat[1] = mkdat(47); fl[1] = 1'b1;
        #1 chk("flush_in_ready", 1, 32'(ir[1]), 0);
        tick();
        fl[1] = 1'b0; iv[1] = 1'b0;
        chk("flush_occ", 1, 32'(occ[1]), 0);
        chk("flush_valid", 1, 32'(ov[1]), 0);
        chk("flush_ctrl", 1, 32'(octl[1]), 0);
        ordy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("flush_no_leak", 1, 32'(ov[1]), 0);
        end
        ordy[1] = 1'b0;

        // Asynchronous reset pulse mid-stream
        for (int j = 1; j <= 2; j++) begin
            iv[1] = 1'b1; ictl[1] = CW'(16'h30 + j); idat[1] = mkdat(48 + j);
            tick();
        end
        ictl[1] = 16'h0033; idat[1] = mkdat(51);
        @(negedge clk);
        #1 clr_n = 1'b0;
        rst_pulses++;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_valid", i, 32'(ov[i]), 0);
            chk("async_ready", i, 32'(ir[i]), 0);
            chk("async_occ", i, 32'(occ[i]), 0);
            chk("async_ctrl", i, 32'(octl[i]), 0);
            chkd("async_data", i, odat[i], '0);
        end
        iv[1] = 1'b0;
        #2 clr_n = 1'b1;
        tick();
        chk("post_rst_ready", 1, 32'(ir[1]), 1);
        iv[1] = 1'b1; ictl[1] = 16'h00AA; idat[1] = mkdat(170); ordy[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        tick();
        chk("post_rst_valid", 1, 32'(ov[1]), 1);
        chk("post_rst_ctrl", 1, 32'(octl[1]), 32'h00AA);
        chkd("post_rst_data", 1, odat[1], mkdat(170));
        tick();
        ordy[1] = 1'b0;

        // Randomised traffic on all depths
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NI; i++) begin
                iv[i]   = 1'($urandom_range(0, 1));
                ordy[i] = 1'($urandom_range(0, 1));
                fl[i]   = ($urandom_range(0, 199) == 0);
                ictl[i] = CW'($urandom);
                idat[i] = {$urandom, $urandom, $urandom};
            end
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
        end
        repeat (20) tick();
        for (int i = 0; i < NI; i++) begin
            chk("final_queue_empty", i, exp_q[i].size(), 0);
            chk("final_occ", i, 32'(occ[i]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
